// File: rtl/pch_unit.sv
// PC high-byte stage: PCH select, carry increment and branch page fix-up.
// Optional PCH_WRAP_FLAG_EN adds a sticky PCH wrap flag (i_wrap_clr/o_pc_wrap).
module pch_unit #(
    parameter logic [7:0] PCH_RESET = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_pch_pch,
    input  logic       i_adh_pch,
    input  logic [7:0] i_adh,
    input  logic       i_pclc,
    input  logic       i_brfix_start,
    input  logic       i_brfix_cross,
    input  logic       i_brfix_dir,
`ifdef PCH_WRAP_FLAG_EN
    input  logic       i_wrap_clr,
    output logic       o_pc_wrap,
`endif
    output logic [7:0] o_pch,
    output logic       o_pchc,
    output logic       o_page_fix
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FIX_INC = 2'd1;
    localparam logic [1:0] FIX_DEC = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] pch_q, pch_d;
    logic [7:0] src;
    logic [8:0] sum;
    logic       pchc;
    logic       wrap_set;

    always_comb begin
        src      = pch_q;
        sum      = 9'd0;
        pch_d    = pch_q;
        state_d  = state_q;
        pchc     = 1'b0;
        wrap_set = 1'b0;
        unique case (state_q)
            FIX_INC: begin
                sum      = {1'b0, pch_q} + 9'd1;
                pch_d    = sum[7:0];
                pchc     = sum[8];
                wrap_set = sum[8];
                state_d  = IDLE;
            end
            FIX_DEC: begin
                pch_d    = pch_q - 8'd1;
                wrap_set = (pch_q == 8'h00);
                state_d  = IDLE;
            end
            default: begin
                // i_pch_pch wins; no select at all simply holds PCH
                if (i_pch_pch)      src = pch_q;
                else if (i_adh_pch) src = i_adh;
                sum      = {1'b0, src} + {8'b0, i_pclc};
                pch_d    = sum[7:0];
                pchc     = sum[8];
                wrap_set = sum[8];
                state_d  = IDLE;
                if (i_brfix_start && i_brfix_cross)
                    state_d = i_brfix_dir ? FIX_DEC : FIX_INC;
            end
        endcase
    end

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            pch_q   <= PCH_RESET;
        end else begin
            state_q <= state_d;
            pch_q   <= pch_d;
        end
    end

`ifdef PCH_WRAP_FLAG_EN
    logic wrap_q, wrap_d;

    // set has priority over a same-edge clear
    always_comb begin
        wrap_d = wrap_q;
        if (i_wrap_clr) wrap_d = 1'b0;
        if (wrap_set)   wrap_d = 1'b1;
    end

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) wrap_q <= 1'b0;
        else            wrap_q <= wrap_d;
    end

    assign o_pc_wrap = wrap_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap_set;
`endif

    assign o_pch      = pch_q;
    assign o_pchc     = pchc;
    assign o_page_fix = (state_q != IDLE);

endmodule

// File: tb/tb_pch_unit.sv
// Self-checking bench for pch_unit: spec-level model checked every posedge
// plus directed literal expectations.
module tb_pch_unit;

    localparam logic [7:0] PR = 8'hC0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pch_pch = 1'b0;
    logic       adh_pch = 1'b0;
    logic [7:0] adh = 8'h00;
    logic       pclc = 1'b0;
    logic       st = 1'b0;
    logic       cr = 1'b0;
    logic       dr = 1'b0;
    logic [7:0] pch;
    logic       pchc;
    logic       pfix;
`ifdef PCH_WRAP_FLAG_EN
    logic       wclr = 1'b0;
    logic       wrap;
`endif

    int n_checks = 0;
    int n_err = 0;

    pch_unit #(.PCH_RESET(PR)) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_pch_pch(pch_pch),
        .i_adh_pch(adh_pch),
        .i_adh(adh),
        .i_pclc(pclc),
        .i_brfix_start(st),
        .i_brfix_cross(cr),
        .i_brfix_dir(dr),
`ifdef PCH_WRAP_FLAG_EN
        .i_wrap_clr(wclr),
        .o_pc_wrap(wrap),
`endif
        .o_pch(pch),
        .o_pchc(pchc),
        .o_page_fix(pfix)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: PCH as an integer, a pending fix-up of +1/-1/0
    int m_pch;
    int m_fix;
    int m_wrap;

    function automatic int m_src();
        if (pch_pch) return m_pch;
        if (adh_pch) return int'(adh);
        return m_pch;
    endfunction

    function automatic int m_pchc();
        if (m_fix == 0) return (m_src() + int'(pclc) > 255) ? 1 : 0;
        return (m_fix == 1 && m_pch == 255) ? 1 : 0;
    endfunction

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pch = PR;
            m_fix = 0;
            m_wrap = 0;
        end else begin
            int nxt;
            int wset;
            if (m_fix != 0) begin
                nxt = (m_pch + m_fix + 256) % 256;
                wset = (m_fix == 1 && m_pch == 255) ||
                       (m_fix == -1 && m_pch == 0);
                m_fix = 0;
            end else begin
                nxt = (m_src() + int'(pclc)) % 256;
                wset = (m_src() + int'(pclc)) > 255;
                if (st && cr) m_fix = dr ? -1 : 1;
            end
`ifdef PCH_WRAP_FLAG_EN
            if (wset) m_wrap = 1;
            else if (wclr) m_wrap = 0;
`else
            if (wset) m_wrap = 0;
`endif
            m_pch = nxt;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            chk("model_pch", int'(pch), m_pch);
            chk("model_page_fix", int'(pfix), (m_fix != 0) ? 1 : 0);
            chk("model_pchc", int'(pchc), m_pchc());
`ifdef PCH_WRAP_FLAG_EN
            chk("model_wrap", int'(wrap), m_wrap);
`endif
        end
    end

    // Inputs change 1 time unit after the falling (active) edge
    task automatic drive(logic pp, logic ap, logic [7:0] a, logic c,
                         logic s, logic x, logic d);
        @(negedge clk);
        #1;
        pch_pch = pp;
        adh_pch = ap;
        adh = a;
        pclc = c;
        st = s;
        cr = x;
        dr = d;
`ifdef PCH_WRAP_FLAG_EN
        wclr = 1'b0;
`endif
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic pre_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("reset_pch", int'(pch), 8'hC0);
        chk("reset_page_fix", int'(pfix), 0);
        rst_n = 1'b1;

        // load via ADH, then increment
        drive(0, 1, 8'h12, 0, 0, 0, 0);
        drive(1, 0, 8'h00, 1, 0, 0, 0);
        chk("adh_load", int'(pch), 8'h12);
        pre_edge();
        chk("inc_pchc0", int'(pchc), 0);
        idle();
        chk("inc_13", int'(pch), 8'h13);

        // priority: pch_pch beats adh_pch
        drive(1, 1, 8'h77, 1, 0, 0, 0);
        idle();
        chk("priority", int'(pch), 8'h14);

        // wrap FF -> 00
        drive(0, 1, 8'hFF, 0, 0, 0, 0);
        drive(1, 0, 8'h00, 1, 0, 0, 0);
        chk("load_ff", int'(pch), 8'hFF);
        pre_edge();
        chk("wrap_pchc", int'(pchc), 1);
        idle();
        chk("wrap_00", int'(pch), 8'h00);
`ifdef PCH_WRAP_FLAG_EN
        chk("wrap_flag_set", int'(wrap), 1);
        idle();
        wclr = 1'b1;
        chk("wrap_flag_hold", int'(wrap), 1);
        idle();
        chk("wrap_flag_clr", int'(wrap), 0);
`endif

        // forward page fix-up, FIX inputs ignored
        drive(0, 1, 8'h40, 0, 0, 0, 0);
        drive(1, 0, 8'h00, 0, 1, 1, 0);
        chk("fi_load", int'(pch), 8'h40);
        drive(0, 1, 8'h99, 1, 1, 1, 1);
        chk("fi_pfix1", int'(pfix), 1);
        chk("fi_hold", int'(pch), 8'h40);
        idle();
        chk("fi_41", int'(pch), 8'h41);
        chk("fi_pfix0", int'(pfix), 0);

        // backward fix-up 00 -> FF
        drive(0, 1, 8'h00, 0, 0, 0, 0);
        drive(1, 0, 8'h00, 0, 1, 1, 1);
        drive(0, 1, 8'h99, 1, 1, 1, 0);
        chk("fd_pfix1", int'(pfix), 1);
        chk("fd_hold", int'(pch), 8'h00);
        pre_edge();
        chk("fd_pchc0", int'(pchc), 0);
        idle();
        chk("fd_ff", int'(pch), 8'hFF);
        chk("fd_pfix0", int'(pfix), 0);

        // start without cross: no fix-up
        drive(1, 0, 8'h00, 0, 1, 0, 1);
        idle();
        chk("nc_pfix", int'(pfix), 0);
        chk("nc_pch", int'(pch), 8'hFF);
        idle();
        chk("nc_pfix2", int'(pfix), 0);

        // FIX_INC from FF carries out
        drive(1, 0, 8'h00, 0, 1, 1, 0);
        idle();
        pre_edge();
        chk("fi_ff_pchc", int'(pchc), 1);
        idle();
        chk("fi_ff_00", int'(pch), 8'h00);

        // async reset in the middle of a fix-up
        drive(0, 1, 8'h40, 0, 1, 1, 0);
        idle();
        chk("rst_fix_pfix", int'(pfix), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pch", int'(pch), 8'hC0);
        chk("async_pfix", int'(pfix), 0);
        #1;
        rst_n = 1'b1;
        idle();
        chk("post_rst_pch", int'(pch), 8'hC0);
        chk("post_rst_pfix", int'(pfix), 0);
        idle();
        chk("post_rst_pch2", int'(pch), 8'hC0);

        // a few mixed cycles for the model checker
        for (int i = 0; i < 20; i++) begin
            drive(logic'(i[0]), logic'(i[1]), 8'(i * 37), logic'(i[2]),
                  logic'(i % 5 == 0), logic'(i % 3 != 0), logic'(i[3]));
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pch_unit.md
Name: pch_unit

Overview:
Program Counter High stage. It consumes the carry out of the PC low-byte stage and holds the PC high byte (PCH). It contains:
- the PCH select (PCH or ADH bus);
- carry-driven increment logic;
- a branch page-fixup state machine that applies a deferred +1/-1 to PCH when a relative branch crosses a page.

Its output drives the ADH-side PC path and the address bus high register.

Parameters:
PCH_RESET, 8'h00, value loaded into PCH on reset.

Ports:
i_clk  input  1  phi2 clock; all state updates on falling edge.
i_reset_n  input  1  reset, asynchronous, active-low.
i_pch_pch  input  1  control: select current PCH as increment source.
i_adh_pch  input  1  control: select ADH bus as increment source.
i_adh  input  8  ADH bus.
i_pclc  input  1  carry in from the PC low-byte stage; increments PCH.
i_brfix_start  input  1  branch low-byte add done this cycle; evaluate page crossing.
i_brfix_cross  input  1  ALU reports the branch low-byte add crossed a page.
i_brfix_dir  input  1  0 = forward offset (fix +1), 1 = backward offset (fix -1).
o_pch  output  8  PCH register.
o_pchc  output  1  combinational carry out of the increment logic (source+i_pclc overflowed).
o_page_fix  output  1  registered; high for exactly the cycle PCH fix-up is being applied; timing generator inserts a cycle while high.

Behaviour:
- Reset (async, i_reset_n low):
  - o_pch = PCH_RESET, state = IDLE, o_page_fix = 0.
  - Optional flag cleared.
  - Reset mid-fixup aborts the fixup; no delayed update after release.
- Register timing: all registers update on the negedge of i_clk.
- States: IDLE, FIX_INC, FIX_DEC. o_page_fix = 1 exactly when state != IDLE.
- Source select, used in IDLE only:
  - i_pch_pch=1 -> source = o_pch (i_pch_pch has priority over i_adh_pch).
  - else i_adh_pch=1 -> source = i_adh.
  - else source = o_pch (hold).
- Increment, IDLE:
  - 9-bit sum = {0,source} + {8'b0,i_pclc}; next o_pch = sum[7:0].
  - o_pchc = sum[8], combinational at all times in IDLE.
  - Wrap: source 8'hFF with i_pclc=1 -> next PCH 8'h00, o_pchc=1.
- IDLE transitions, evaluated at negedge:
  - i_brfix_start=1 and i_brfix_cross=1 -> FIX_INC if i_brfix_dir=0, else FIX_DEC. PCH still takes the normal select/increment result this edge.
  - i_brfix_start=1 and i_brfix_cross=0 -> stay IDLE, o_page_fix stays 0.
  - i_brfix_start=0 -> stay IDLE.
- FIX_INC: at next negedge, o_pch <= o_pch + 1 (mod 256), state -> IDLE.
- FIX_DEC: at next negedge, o_pch <= o_pch - 1 (mod 256; 8'h00 -> 8'hFF), state -> IDLE.
- Rules while in either FIX state:
  - i_pch_pch, i_adh_pch, i_adh, i_pclc are ignored.
  - o_pchc = 1 only for FIX_INC with o_pch=8'hFF, else 0.
  - i_brfix_start is ignored; no back-to-back fixup is queued.
- Latency:
  - Select/increment: one negedge.
  - Fixup: o_page_fix high for exactly one cycle, starting the cycle after start; the corrected PCH is visible after the second negedge.
- i_brfix_cross and i_brfix_dir are don't-care when i_brfix_start=0.

Optional Feature:
PCH_WRAP_FLAG_EN
- Defined:
  - Adds input i_wrap_clr (1 bit) and output o_pc_wrap (1 bit, registered, reset 0).
  - o_pc_wrap sets at the negedge where PCH goes 8'hFF->8'h00 by increment or FIX_INC, or 8'h00->8'hFF by FIX_DEC.
  - It remains set until an edge with i_wrap_clr=1. If set and clear occur on the same edge, set wins.
- Not defined: neither port exists and there is no extra logic; all other behaviour is identical.

Test Plan:
1. Reset with PCH_RESET=8'hC0 -> o_pch=8'hC0, o_page_fix=0. Async reset assert mid-cycle -> o_pch=8'hC0 immediately, without a clock edge.
2. i_adh_pch=1, i_adh=8'h12, i_pclc=0 -> o_pch=8'h12 after one negedge. Then i_pch_pch=1, i_pclc=1 -> 8'h13, o_pchc=0 before the edge.
3. o_pch=8'hFF, i_pch_pch=1, i_pclc=1 -> o_pchc=1 before the edge, o_pch=8'h00 after it. With PCH_WRAP_FLAG_EN, o_pc_wrap=1 until i_wrap_clr.
4. o_pch=8'h40, i_brfix_start=1, cross=1, dir=0, i_pch_pch=1, i_pclc=0 -> next cycle o_page_fix=1, o_pch=8'h40. Then o_pch=8'h41, o_page_fix=0. Inputs i_adh_pch=1, i_adh=8'h99 during FIX are ignored.
5. o_pch=8'h00, start=1, cross=1, dir=1 -> FIX_DEC, then o_pch=8'hFF. Repeat with cross=0 -> o_page_fix never asserts, o_pch unchanged.
6. Enter FIX_INC, assert i_reset_n=0 during o_page_fix=1, release -> o_pch=PCH_RESET, state IDLE, no delayed increment.
